// File: rtl/corr_peak_detector.sv
// Peak search over one correlation frame: squared magnitude per sample, running
// maximum with earliest-index tie break, one report per frame on a valid/ready port.
module corr_peak_detector #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNT_W-1:0]      corr_numb,
  input  logic [2*DATA_W-1:0]   threshold,
  input  logic [2*DATA_W-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      res_index,
  output logic [2*DATA_W-1:0]   res_mag,
  output logic [2*DATA_W-1:0]   res_data,
  output logic                  res_above,
  output logic                  busy
);

  localparam int MW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  state_t           state_q, state_d;
  logic             tready_q, tready_d;
  logic             res_valid_q, res_valid_d;
  logic             load_res;
  logic [CNT_W-1:0] numb_q, numb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    thr_q, thr_d;
  logic             hs;
  logic [CNT_W-1:0] beat_idx;

  // Squarers: the only value that needs bit SW-1 is (-2^(DATA_W-1))^2, whose
  // wrapped signed result still carries the correct unsigned bit pattern.
  logic signed [SW-1:0] re_ext, im_ext, re_sq, im_sq;

  logic             s1_valid_q, s1_first_q;
  logic [SW-1:0]    s1_re2_q, s1_im2_q;
  logic [MW-1:0]    s1_data_q;
  logic [CNT_W-1:0] s1_idx_q;
  logic [MW-1:0]    s1_mag;
  logic             s2_valid_q;

  logic [MW-1:0]    max_mag_q, max_data_q;
  logic [CNT_W-1:0] max_idx_q;

  logic [CNT_W-1:0] res_index_q;
  logic [MW-1:0]    res_mag_q, res_data_q;
  logic             res_above_q;

  assign hs       = s_axis_tvalid && tready_q;
  assign beat_idx = (state_q == IDLE) ? '0 : cnt_q;

  assign re_ext = {{(DATA_W-1){s_axis_tdata[DATA_W-1]}}, s_axis_tdata[DATA_W-1:0]};
  assign im_ext = {{(DATA_W-1){s_axis_tdata[MW-1]}}, s_axis_tdata[MW-1:DATA_W]};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign s1_mag = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};

  always_comb begin
    state_d     = state_q;
    numb_d      = numb_q;
    thr_d       = thr_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    load_res    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          numb_d  = (corr_numb == '0) ? CNT_W'(1) : corr_numb;
          thr_d   = threshold;
          cnt_d   = CNT_W'(1);
          state_d = (corr_numb <= CNT_W'(1)) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == numb_q - CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          load_res    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that tready stays low while reset is held.
    tready_d = (state_d == IDLE) || (state_d == SCAN);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      res_valid_q <= 1'b0;
      numb_q      <= '0;
      cnt_q       <= '0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      res_valid_q <= res_valid_d;
      numb_q      <= numb_d;
      cnt_q       <= cnt_d;
      thr_q       <= thr_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_re2_q   <= '0;
      s1_im2_q   <= '0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      max_mag_q  <= '0;
      max_data_q <= '0;
      max_idx_q  <= '0;
    end else begin
      s1_valid_q <= hs;
      if (hs) begin
        s1_re2_q   <= re_sq;
        s1_im2_q   <= im_sq;
        s1_data_q  <= s_axis_tdata;
        s1_idx_q   <= beat_idx;
        s1_first_q <= (state_q == IDLE);
      end
      s2_valid_q <= s1_valid_q;
      // Strict compare keeps the earliest index on ties.
      if (s1_valid_q && (s1_first_q || (s1_mag > max_mag_q))) begin
        max_mag_q  <= s1_mag;
        max_data_q <= s1_data_q;
        max_idx_q  <= s1_idx_q;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      res_index_q <= '0;
      res_mag_q   <= '0;
      res_data_q  <= '0;
      res_above_q <= 1'b0;
    end else if (load_res) begin
      res_index_q <= max_idx_q;
      res_mag_q   <= max_mag_q;
      res_data_q  <= max_data_q;
      res_above_q <= (max_mag_q > thr_q);
    end
  end

  assign s_axis_tready = tready_q;
  assign res_valid     = res_valid_q;
  assign res_index     = res_index_q;
  assign res_mag       = res_mag_q;
  assign res_data      = res_data_q;
  assign res_above     = res_above_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/corr_peak_detector.md
Name: corr_peak_detector

Overview:
- Downstream consumer of the correlation output stream of fast_fourier_correlation: one frame of corr_numb complex samples in, one peak report out.
- Computes the squared magnitude of each sample and tracks the maximum and its index over the frame.
- After the frame, presents index, magnitude, raw sample and a threshold flag on a valid/ready result port.
- Used by the acquisition controller to locate the correlation peak without reading the whole stream.

Parameters:
- DATA_W, 16, width of each of re/im (s_axis_tdata is 2*DATA_W)
- CNT_W, 16, width of corr_numb and res_index

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- corr_numb  in  CNT_W  samples per frame, sampled on the first beat of each frame
- threshold  in  2*DATA_W  unsigned magnitude threshold, sampled with corr_numb
- s_axis_tdata  in  2*DATA_W  [DATA_W-1:0]=re, [2*DATA_W-1:DATA_W]=im, both signed
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  block accepts sample
- res_valid  out  1  peak report valid
- res_ready  in  1  consumer accepts report
- res_index  out  CNT_W  0-based index of the peak within the frame
- res_mag  out  2*DATA_W  re^2+im^2 of the peak, unsigned
- res_data  out  2*DATA_W  raw tdata of the peak sample
- res_above  out  1  res_mag > threshold (strict)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, released synchronously to aclk):
  - All outputs 0, state IDLE, pipeline valids 0.
  - s_axis_tready is 0 during reset and 1 in the first cycle after release.
- States:
  - IDLE: s_axis_tready=1. First handshake latches corr_numb and threshold, processes that beat as index 0, then goes to SCAN. If the latched corr_numb<=1, goes straight to DRAIN.
  - SCAN: s_axis_tready=1. Each handshake (tvalid&&tready) increments the sample counter. The handshake with index corr_numb-1 is the last beat; s_axis_tready drops the next cycle and the block goes to DRAIN.
  - DRAIN: s_axis_tready=0. Waits for the 2-stage pipeline to empty, then loads the result registers, asserts res_valid and goes to REPORT.
  - REPORT: s_axis_tready=0. Outputs are held stable while res_valid&&!res_ready. On res_valid&&res_ready, res_valid drops the next cycle and the block returns to IDLE, ready for a new frame.
- corr_numb=0 is treated as 1.
- Input gaps (tvalid low) stall the counter only; the pipeline keeps flowing.
- Pipeline:
  - Stage 1 registers re*re, im*im (each 2*DATA_W-1 bits, unsigned), plus tdata and index, with a valid bit.
  - Stage 2 forms the sum (2*DATA_W bits, no overflow: max 2^(2*DATA_W-1) for re=im=-2^(DATA_W-1)). It compares against the running max and updates on strict greater-than, so ties keep the earliest index.
  - The first valid sample of a frame always loads the running max.
- Latency: res_valid rises exactly 3 cycles after the aclk edge on which the last beat handshakes.
- res_above is computed from the final res_mag and the threshold latched at frame start; changes to the threshold input mid-frame are ignored.
- No input back-pressure inside a frame beyond what is defined above; samples are never dropped or duplicated.
- Reset mid-frame or mid-REPORT aborts immediately; any partial frame is discarded. The next frame after release starts at index 0.
- A new frame cannot begin until the report is consumed; s_axis_tready stays 0 through DRAIN/REPORT.

Test Plan:
- Impulse: corr_numb=8, all zero except sample 5 = re 100, im -50, threshold 0 -> res_index=5, res_mag=12500, res_data=0xFFCE0064, res_above=1, res_valid 3 cycles after last beat.
- Tie/earliest: corr_numb=4, samples (3,4),(0,5),(5,0),(1,1) -> res_index=0, res_mag=25. Then threshold=25 -> res_above=0.
- Extremes: corr_numb=2, sample 1 = re -32768, im -32768 -> res_mag=0x80000000, index 1. corr_numb=0 and =1 -> single-beat frame, index 0.
- Back-pressure: random tvalid gaps on input; res_ready held low 10 cycles -> res_* stable, s_axis_tready=0 throughout; after the report handshake, s_axis_tready=1 the next cycle.
- Reset mid-frame: areset for 2 cycles after 3 of 8 beats -> all outputs 0. A new 8-beat frame with its peak at index 2 reports index 2 (no stale max).
- Back-to-back: 3 frames, corr_numb=16, res_ready tied 1 -> 3 reports matching a reference model; no accepted beats lost.
